// File: rtl/i2s_receiver_if.sv
// Signal bundle between an I2S transmitter/consumer (master) and the receiver (slave):
// serial lrclk/sdin in, held stereo frame with valid/ready handshake and error pulses out.
interface i2s_receiver_if #(
    parameter int DATA_WIDTH = 24
);
    logic                  lrclk;
    logic                  sdin;
    logic                  ready;
    logic [DATA_WIDTH-1:0] left_data;
    logic [DATA_WIDTH-1:0] right_data;
    logic                  valid;
    logic                  overrun;
    logic                  frame_err;

    modport master (
        output lrclk, sdin, ready,
        input  left_data, right_data, valid, overrun, frame_err
    );

    modport slave (
        input  lrclk, sdin, ready,
        output left_data, right_data, valid, overrun, frame_err
    );
endinterface

// File: rtl/i2s_receiver.sv
// I2S receiver: deserialises left/right words from lrclk/sdin and presents
// complete stereo frames on held outputs through a valid/ready handshake.
module i2s_receiver #(
    parameter int DATA_WIDTH = 24,
    parameter int BIT_DELAY  = 1
) (
    input logic           sclk,
    input logic           rst,
    i2s_receiver_if.slave bus
);
    typedef enum logic [1:0] {SYNC, DELAY, SHIFT, WAIT} state_t;

    localparam logic [4:0] BIT_LOAD   = 5'(DATA_WIDTH - 1);
    localparam logic [1:0] DELAY_LOAD = 2'((BIT_DELAY > 0) ? BIT_DELAY - 1 : 0);

    state_t                r_state;
    logic                  r_prevLr;
    logic                  r_channel;
    logic                  r_leftPending;
    logic [1:0]            r_delayCnt;
    logic [4:0]            r_bitCnt;
    logic [DATA_WIDTH-2:0] r_shift;
    logic [DATA_WIDTH-1:0] r_leftStage;
    logic [DATA_WIDTH-1:0] r_leftData;
    logic [DATA_WIDTH-1:0] r_rightData;
    logic                  r_valid;
    logic                  r_overrun;
    logic                  r_frameErr;

    logic                  w_edge;
    logic                  w_lastBit;
    logic                  w_abort;
    logic [DATA_WIDTH-1:0] w_word;

    assign w_edge    = (bus.lrclk != r_prevLr);
    assign w_lastBit = (r_state == SHIFT) && (r_bitCnt == 5'd0);
    assign w_abort   = w_edge && ((r_state == DELAY) || ((r_state == SHIFT) && !w_lastBit));
    assign w_word    = {r_shift, bus.sdin};

    assign bus.left_data  = r_leftData;
    assign bus.right_data = r_rightData;
    assign bus.valid      = r_valid;
    assign bus.overrun    = r_overrun;
    assign bus.frame_err  = r_frameErr;

    // The right word is forwarded straight to the output alongside the left staging
    // register, so a frame is visible the cycle after its last bit. Any lrclk edge
    // restarts capture; the edge handling sits last so it overrides the word bookkeeping.
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_state       <= SYNC;
            r_prevLr      <= bus.lrclk;
            r_channel     <= 1'b0;
            r_leftPending <= 1'b0;
            r_delayCnt    <= 2'd0;
            r_bitCnt      <= 5'd0;
            r_shift       <= '0;
            r_leftStage   <= '0;
            r_leftData    <= '0;
            r_rightData   <= '0;
            r_valid       <= 1'b0;
            r_overrun     <= 1'b0;
            r_frameErr    <= 1'b0;
        end else begin
            r_prevLr   <= bus.lrclk;
            r_overrun  <= 1'b0;
            r_frameErr <= 1'b0;
            if (r_valid && bus.ready) begin
                r_valid <= 1'b0;
            end
            if (r_state == SHIFT) begin
                r_shift <= w_word[DATA_WIDTH-2:0];
            end

            if (w_lastBit) begin
                r_state <= WAIT;
                if (!r_channel) begin
                    r_leftStage   <= w_word;
                    r_leftPending <= 1'b1;
                end else if (r_leftPending) begin
                    r_leftPending <= 1'b0;
                    if (!r_valid || bus.ready) begin
                        r_leftData  <= r_leftStage;
                        r_rightData <= w_word;
                        r_valid     <= 1'b1;
                    end else begin
                        r_overrun <= 1'b1;
                    end
                end
            end else if (r_state == DELAY) begin
                if (r_delayCnt == 2'd0) begin
                    r_state  <= SHIFT;
                    r_bitCnt <= BIT_LOAD;
                end else begin
                    r_delayCnt <= r_delayCnt - 2'd1;
                end
            end else if (r_state == SHIFT) begin
                r_bitCnt <= r_bitCnt - 5'd1;
            end

            if (w_abort) begin
                r_frameErr    <= 1'b1;
                r_leftPending <= 1'b0;
            end
            if (w_edge) begin
                r_channel <= bus.lrclk;
                if (BIT_DELAY == 0) begin
                    r_state  <= SHIFT;
                    r_bitCnt <= BIT_LOAD;
                end else begin
                    r_state    <= DELAY;
                    r_delayCnt <= DELAY_LOAD;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: two instances (BIT_DELAY 1 and 0) driven from pre-built
// slot streams, checked every cycle against a slot-level frame model plus literal pins.
module tb_i2s_receiver;
    localparam int DW   = 24;
    localparam int MAXC = 4096;

    logic sclk;
    logic rst0;
    logic rst1;

    i2s_receiver_if #(.DATA_WIDTH(DW)) bus0 ();
    i2s_receiver_if #(.DATA_WIDTH(DW)) bus1 ();

    i2s_receiver #(.DATA_WIDTH(DW), .BIT_DELAY(1)) dut0 (.sclk(sclk), .rst(rst0), .bus(bus0.slave));
    i2s_receiver #(.DATA_WIDTH(DW), .BIT_DELAY(0)) dut1 (.sclk(sclk), .rst(rst1), .bus(bus1.slave));

    // Per-cycle stimulus and the events each stream implies.
    bit            lrA  [2][MAXC];
    bit            sdA  [2][MAXC];
    bit            rdyA [2][MAXC];
    bit            rstA [2][MAXC];
    bit            frmA [2][MAXC];
    bit            errA [2][MAXC];
    logic [DW-1:0] fLA  [2][MAXC];
    logic [DW-1:0] fRA  [2][MAXC];

    int            pos     [2];
    bit            curLr   [2];
    bit            pend    [2];
    logic [DW-1:0] pendL   [2];
    int            rdyMode [2];
    int            bdOf    [2];

    bit            mV [2];
    logic [DW-1:0] mL [2];
    logic [DW-1:0] mR [2];

    int passCount;
    int checkCount;
    int ncyc;

    typedef struct {
        int            d;
        int            c;
        int            k;
        logic [DW-1:0] v;
    } lit_t;
    lit_t lits[$];

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    task automatic addLit(input int d, input int c, input int k, input logic [DW-1:0] v);
        lit_t t;
        t.d = d;
        t.c = c;
        t.k = k;
        t.v = v;
        lits.push_back(t);
    endtask

    task automatic putCycle(input int d, input bit lr, input bit r);
        lrA[d][pos[d]]  = lr;
        rstA[d][pos[d]] = r;
        rdyA[d][pos[d]] = (rdyMode[d] == 2) ? bit'($urandom_range(0, 1)) : bit'(rdyMode[d] == 1);
        pos[d]++;
    endtask

    task automatic idle(input int d, input int n);
        repeat (n) putCycle(d, curLr[d], 1'b0);
    endtask

    task automatic resetCycles(input int d, input int n);
        repeat (n) putCycle(d, curLr[d], 1'b1);
        pend[d] = 1'b0;
    endtask

    // One lrclk slot of L cycles starting at its edge; the word sits at edge+bd+1 onward.
    // rstOff >= 0 cuts the slot with a 3-cycle reset that many cycles after the edge.
    task automatic slot(input int d, input int L, input logic [DW-1:0] w, input int rstOff, output int cDone);
        int e;
        int bd;
        int span;
        bit ch;
        bit full;
        bd   = bdOf[d];
        e    = pos[d];
        curLr[d] = ~curLr[d];
        ch   = curLr[d];
        span = (rstOff >= 0) ? rstOff : L;
        full = (rstOff < 0) && (L >= bd + DW);
        cDone = -1;
        for (int i = 0; i < DW; i++) begin
            if (full || (bd + 1 + i < span)) sdA[d][e + bd + 1 + i] = w[DW - 1 - i];
        end
        repeat (span) putCycle(d, ch, 1'b0);
        if (rstOff >= 0) begin
            resetCycles(d, 3);
        end else if (full) begin
            cDone = e + bd + DW;
            if (!ch) begin
                pend[d]  = 1'b1;
                pendL[d] = w;
            end else if (pend[d]) begin
                frmA[d][cDone] = 1'b1;
                fLA[d][cDone]  = pendL[d];
                fRA[d][cDone]  = w;
                pend[d]        = 1'b0;
            end
        end else begin
            errA[d][e + L] = 1'b1;
            pend[d]        = 1'b0;
        end
    endtask

    task automatic cmp(input string name, input int d, input int n, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s dut%0d cycle %0d: got %h, expected %h", name, d, n, got, exp);
    endtask

    task automatic applyStimulus(input int n);
        bus0.lrclk = lrA[0][n];
        bus0.sdin  = sdA[0][n];
        bus0.ready = rdyA[0][n];
        rst0       = rstA[0][n];
        bus1.lrclk = lrA[1][n];
        bus1.sdin  = sdA[1][n];
        bus1.ready = rdyA[1][n];
        rst1       = rstA[1][n];
    endtask

    // Advance the handshake model by the posedge of cycle n, then compare.
    task automatic checkOutput(input int d, input int n, input logic v, input logic [DW-1:0] l,
                               input logic [DW-1:0] r, input logic ov, input logic fe);
        bit eOv;
        bit eFe;
        eOv = 1'b0;
        eFe = 1'b0;
        if (rstA[d][n]) begin
            mV[d] = 1'b0;
            mL[d] = '0;
            mR[d] = '0;
        end else begin
            eFe = errA[d][n];
            if (frmA[d][n]) begin
                if (!mV[d] || rdyA[d][n]) begin
                    mL[d] = fLA[d][n];
                    mR[d] = fRA[d][n];
                    mV[d] = 1'b1;
                end else begin
                    eOv = 1'b1;
                end
            end else if (mV[d] && rdyA[d][n]) begin
                mV[d] = 1'b0;
            end
        end
        cmp("valid", d, n, DW'(v), DW'(mV[d]));
        cmp("left_data", d, n, l, mL[d]);
        cmp("right_data", d, n, r, mR[d]);
        cmp("overrun", d, n, DW'(ov), DW'(eOv));
        cmp("frame_err", d, n, DW'(fe), DW'(eFe));
        foreach (lits[i]) begin
            if (lits[i].d == d && lits[i].c == n) begin
                case (lits[i].k)
                    0:       cmp("lit_valid", d, n, DW'(v), lits[i].v);
                    1:       cmp("lit_left", d, n, l, lits[i].v);
                    2:       cmp("lit_right", d, n, r, lits[i].v);
                    3:       cmp("lit_overrun", d, n, DW'(ov), lits[i].v);
                    default: cmp("lit_frame_err", d, n, DW'(fe), lits[i].v);
                endcase
            end
        end
    endtask

    task automatic litFrame(input int d, input int c, input logic [DW-1:0] l, input logic [DW-1:0] r);
        addLit(d, c, 0, 1);
        addLit(d, c, 1, l);
        addLit(d, c, 2, r);
    endtask

    initial begin
        int c;
        int e;
        int q;
        passCount  = 0;
        checkCount = 0;
        bdOf[0] = 1;
        bdOf[1] = 0;
        for (int d = 0; d < 2; d++) begin
            pos[d]   = 0;
            pend[d]  = 1'b0;
            mV[d]    = 1'b0;
            mL[d]    = '0;
            mR[d]    = '0;
            curLr[d] = 1'b1;
            rdyMode[d] = 1;
            for (int n = 0; n < MAXC; n++) sdA[d][n] = bit'($urandom_range(0, 1));
        end

        // Instance 0, BIT_DELAY 1: minimum-length slots, then 32-bit slots with padding.
        resetCycles(0, 4);
        idle(0, 5);
        addLit(0, 2, 0, 0);
        addLit(0, 2, 1, 0);
        slot(0, 25, 24'hA5A5A5, -1, c);
        slot(0, 25, 24'h5A5A5A, -1, c);
        addLit(0, c - 1, 0, 0);
        litFrame(0, c, 24'hA5A5A5, 24'h5A5A5A);
        addLit(0, c + 1, 0, 0);
        for (int k = 0; k < 2; k++) begin
            slot(0, 32, 24'h800001, -1, c);
            slot(0, 32, 24'h7FFFFF, -1, c);
            litFrame(0, c, 24'h800001, 24'h7FFFFF);
            addLit(0, c + 1, 0, 0);
        end
        idle(0, 4);

        // Consumer stalled across two frames.
        rdyMode[0] = 0;
        slot(0, 32, 24'h111111, -1, c);
        slot(0, 32, 24'h222222, -1, c);
        litFrame(0, c, 24'h111111, 24'h222222);
        slot(0, 32, 24'h333333, -1, c);
        slot(0, 32, 24'h444444, -1, c);
        litFrame(0, c, 24'h111111, 24'h222222);
        addLit(0, c, 3, 1);
        addLit(0, c + 1, 3, 0);
        rdyMode[0] = 1;
        q = pos[0];
        addLit(0, q - 1, 0, 1);
        idle(0, 6);
        addLit(0, q, 0, 0);
        addLit(0, q, 1, 24'h111111);

        // Left word cut after 10 bits.
        e = pos[0];
        slot(0, 12, 24'hABCDEF, -1, c);
        addLit(0, e + 12, 4, 1);
        addLit(0, e + 13, 4, 0);
        slot(0, 32, 24'h0F0F0F, -1, c);
        addLit(0, c, 0, 0);
        addLit(0, c + 1, 0, 0);
        slot(0, 32, 24'h123456, -1, c);
        slot(0, 32, 24'h654321, -1, c);
        litFrame(0, c, 24'h123456, 24'h654321);
        idle(0, 4);

        // Reset at bit 12 of a right word.
        slot(0, 32, 24'h0A0B0C, -1, c);
        e = pos[0];
        slot(0, 32, 24'hDDDDDD, 14, c);
        addLit(0, e + 14, 0, 0);
        addLit(0, e + 14, 1, 0);
        addLit(0, e + 14, 2, 0);
        addLit(0, e + 15, 4, 0);
        idle(0, 6);
        slot(0, 32, 24'h13579B, -1, c);
        slot(0, 32, 24'h2468AC, -1, c);
        addLit(0, c - 1, 0, 0);
        litFrame(0, c, 24'h13579B, 24'h2468AC);

        rdyMode[0] = 2;
        for (int k = 0; k < 40; k++) slot(0, $urandom_range(6, 40), DW'($urandom), -1, c);
        slot(0, 32, DW'($urandom), -1, c);
        slot(0, 32, DW'($urandom), -1, c);
        idle(0, 8);

        // Instance 1, BIT_DELAY 0: MSB sampled the cycle after the edge.
        resetCycles(1, 4);
        idle(1, 5);
        slot(1, 24, 24'hC00003, -1, c);
        slot(1, 24, 24'h3FFFFC, -1, c);
        litFrame(1, c, 24'hC00003, 24'h3FFFFC);
        addLit(1, c + 1, 0, 0);
        slot(1, 30, 24'hFFFFFF, -1, c);
        slot(1, 24, 24'h000001, -1, c);
        litFrame(1, c, 24'hFFFFFF, 24'h000001);
        rdyMode[1] = 2;
        for (int k = 0; k < 30; k++) slot(1, $urandom_range(3, 34), DW'($urandom), -1, c);
        slot(1, 30, DW'($urandom), -1, c);
        slot(1, 30, DW'($urandom), -1, c);
        idle(1, 8);

        ncyc = ((pos[0] > pos[1]) ? pos[0] : pos[1]) + 4;
        for (int d = 0; d < 2; d++) idle(d, ncyc - pos[d]);

        for (int n = 0; n < ncyc; n++) begin
            applyStimulus(n);
            @(posedge sclk);
            #1;
            checkOutput(0, n, bus0.valid, bus0.left_data, bus0.right_data, bus0.overrun, bus0.frame_err);
            checkOutput(1, n, bus1.valid, bus1.left_data, bus1.right_data, bus1.overrun, bus1.frame_err);
            @(negedge sclk);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/i2s_receiver.md
I2S_RECEIVER -- requirements
Module: i2s_receiver

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 24, meaning bits per channel word (valid range 8..31).
REQ-002 The block SHALL have parameter BIT_DELAY, default 1, meaning the number of sclk edges between the lrclk-change detection and the MSB sample (valid range 0..3).
REQ-003 The block SHALL have port sclk  input  1  bit clock; all logic samples on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset, clocked by sclk.
REQ-005 The block SHALL have port lrclk  input  1  word select: 0 = left channel, 1 = right channel.
REQ-006 The block SHALL have port sdin  input  1  serial data, MSB first.
REQ-007 The block SHALL have port left_data  output  DATA_WIDTH  held left sample of the current frame.
REQ-008 The block SHALL have port right_data  output  DATA_WIDTH  held right sample of the current frame.
REQ-009 The block SHALL have port valid  output  1  stereo frame available on left_data/right_data.
REQ-010 The block SHALL have port ready  input  1  consumer accepts the frame when valid && ready.
REQ-011 The block SHALL have port overrun  output  1  one-cycle pulse when a completed frame is dropped.
REQ-012 The block SHALL have port frame_err  output  1  one-cycle pulse when a word is truncated by an early lrclk change.

Function
REQ-013 Edge detection SHALL use register prev_lr: cycle E is any posedge where lrclk != prev_lr; prev_lr <= lrclk every cycle.
REQ-014 The state machine SHALL have four states: SYNC, DELAY, SHIFT, WAIT.
REQ-015 SYNC: the block SHALL discard sdin until the first edge; on edge -> DELAY, or -> SHIFT if BIT_DELAY==0.
REQ-016 DELAY: the block SHALL count BIT_DELAY-1 further cycles, then -> SHIFT, so the MSB is sampled at posedge E+BIT_DELAY+1.
REQ-017 SHIFT: the block SHALL shift sdin into shift_reg LSB-side each cycle for exactly DATA_WIDTH cycles; bit counter runs DATA_WIDTH-1 down to 0.
REQ-018 The channel of a word SHALL be the lrclk value sampled at cycle E and latched at E.
REQ-019 On the last bit, the completed word SHALL be written to the left or right staging register in the same cycle, then -> WAIT.
REQ-020 WAIT: the block SHALL ignore sdin (slot padding bits) until the next edge, then -> DELAY/SHIFT as in REQ-015.
REQ-021 A frame SHALL complete when a right word completes after a left word completed since the last frame; a right word without a preceding left word SHALL be discarded silently.
REQ-022 On frame completion, if valid==0 or ready==1 in that cycle, the block SHALL copy the staging registers to left_data/right_data and set valid=1 on the next cycle.
REQ-023 On frame completion with valid==1 and ready==0, the block SHALL keep the old output and pulse overrun for one cycle.
REQ-024 valid SHALL clear the cycle after valid && ready, unless a new frame loads in that same cycle, in which case valid stays 1.
REQ-025 Outputs left_data/right_data SHALL be stable while valid==1 and ready==0.
REQ-026 An edge during DELAY or SHIFT SHALL pulse frame_err for one cycle, drop the partial word, clear the left-pending flag, and restart capture for the new channel, the edge counting as a new E.
REQ-027 An edge arriving exactly in the last-bit cycle SHALL complete the word normally and start the next word.

Reset
REQ-028 When rst is high at a posedge, the block SHALL enter SYNC; valid=0, overrun=0, frame_err=0, left_data=0, right_data=0, staging registers=0, left-pending=0, and prev_lr<=lrclk.
REQ-029 When rst is asserted mid-word, the block SHALL discard the partial word with no frame_err; the first lrclk edge after rst deassertion SHALL begin capture.

Verification
REQ-030 The bench SHALL cover: reset, then a transmitter-format frame left=0xA5A5A5, right=0x5A5A5A with ready=1 -> valid=1 for one cycle with those exact values.
REQ-031 The bench SHALL cover: 32-bit slots carrying 24-bit words 0x800001/0x7FFFFF -> padding ignored, data exact, one frame per lrclk period.
REQ-032 The bench SHALL cover: ready=0 across two frames -> first frame held on outputs, overrun pulses once, second frame lost.
REQ-033 The bench SHALL cover: lrclk toggling after 10 bits of a left word -> frame_err pulse, no valid for that frame, next full frame captured correctly.
REQ-034 The bench SHALL cover: rst asserted at bit 12 of a right word -> outputs 0, no valid/frame_err, and the first full left+right pair after reset is delivered.
REQ-035 The bench SHALL cover: BIT_DELAY=0 with MSB aligned to the edge cycle, sending 0xC00003 -> exact capture.
